// File: rtl/status_reg.sv
// status_reg: 6502 processor status (P) register.
// Holds N, V, D, I, Z, C. ALU-sourced flag updates are deferred one cycle so they
// line up with the ALU's registered flag outputs. Immediate flag commands applied
// on the same edge as a deferred update take priority, since they come later in
// program order.
// Optional feature macro: STATUS_DECIMAL_EN. When defined, D drives the ALU BCD input.
// When undefined (2A03-style), D_bcd is tied low, but D is still stored and readable.

module status_reg (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       RDY,
    input  logic [3:0] flag_op,
    input  logic       alu_CO,
    input  logic       alu_V,
    input  logic       alu_Z,
    input  logic       alu_N,
    input  logic [7:0] DB,
    input  logic       irq_n,
    input  logic       push_brk,
    output logic [7:0] P,
    output logic       C_fwd,
    output logic       D_bcd,
    output logic       irq_pending
);

    localparam logic [3:0] OpNz   = 4'h1;
    localparam logic [3:0] OpNzc  = 4'h2;
    localparam logic [3:0] OpNvzc = 4'h3;
    localparam logic [3:0] OpBit  = 4'h4;
    localparam logic [3:0] OpPlp  = 4'h5;
    localparam logic [3:0] OpClc  = 4'h6;
    localparam logic [3:0] OpSec  = 4'h7;
    localparam logic [3:0] OpCli  = 4'h8;
    localparam logic [3:0] OpSei  = 4'h9;
    localparam logic [3:0] OpCld  = 4'hA;
    localparam logic [3:0] OpSed  = 4'hB;
    localparam logic [3:0] OpClv  = 4'hC;
    localparam logic [3:0] OpIrq  = 4'hD;

    // Architectural flags
    logic n_q, v_q, d_q, i_q, z_q, c_q;
    logic n_d, v_d, d_d, i_d, z_d, c_d;
    // Pending deferred-update bits
    logic pn_q, pv_q, pz_q, pc_q;
    logic pn_d, pv_d, pz_d, pc_d;
    // IRQ synchroniser
    logic irq_q;

    // DB[5:4] have no flag behind them (bit 5 constant, bit 4 is B).
    logic unused_db;
    assign unused_db = ^DB[5:4];

    // Next-state: apply pending ALU flags first, then let immediate ops override.
    always_comb begin
        n_d  = n_q;
        v_d  = v_q;
        d_d  = d_q;
        i_d  = i_q;
        z_d  = z_q;
        c_d  = c_q;
        pn_d = 1'b0;
        pv_d = 1'b0;
        pz_d = 1'b0;
        pc_d = 1'b0;

        if (pn_q) n_d = alu_N;
        if (pv_q) v_d = alu_V;
        if (pz_q) z_d = alu_Z;
        if (pc_q) c_d = alu_CO;

        case (flag_op)
            OpNz: begin
                pn_d = 1'b1;
                pz_d = 1'b1;
            end
            OpNzc: begin
                pn_d = 1'b1;
                pz_d = 1'b1;
                pc_d = 1'b1;
            end
            OpNvzc: begin
                pn_d = 1'b1;
                pv_d = 1'b1;
                pz_d = 1'b1;
                pc_d = 1'b1;
            end
            OpBit: begin
                n_d  = DB[7];
                v_d  = DB[6];
                pz_d = 1'b1;
            end
            OpPlp: begin
                n_d = DB[7];
                v_d = DB[6];
                d_d = DB[3];
                i_d = DB[2];
                z_d = DB[1];
                c_d = DB[0];
            end
            OpClc:   c_d = 1'b0;
            OpSec:   c_d = 1'b1;
            OpCli:   i_d = 1'b0;
            OpSei:   i_d = 1'b1;
            OpCld:   d_d = 1'b0;
            OpSed:   d_d = 1'b1;
            OpClv:   v_d = 1'b0;
            OpIrq:   i_d = 1'b1;
            default: ;
        endcase
    end

    // State register: reset wins, IRQ sync always runs, flags advance only when RDY.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            n_q   <= 1'b0;
            v_q   <= 1'b0;
            d_q   <= 1'b0;
            i_q   <= 1'b1;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
            pn_q  <= 1'b0;
            pv_q  <= 1'b0;
            pz_q  <= 1'b0;
            pc_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            irq_q <= ~irq_n;
            if (RDY) begin
                n_q  <= n_d;
                v_q  <= v_d;
                d_q  <= d_d;
                i_q  <= i_d;
                z_q  <= z_d;
                c_q  <= c_d;
                pn_q <= pn_d;
                pv_q <= pv_d;
                pz_q <= pz_d;
                pc_q <= pc_d;
            end
        end
    end

    // Outputs: carry forwarded from the ALU while a C update is in flight.
    always_comb begin
        P           = {n_q, v_q, 1'b1, push_brk, d_q, i_q, z_q, c_q};
        C_fwd       = pc_q ? alu_CO : c_q;
        irq_pending = irq_q & ~i_q;
`ifdef STATUS_DECIMAL_EN
        D_bcd       = d_q;
`else
        D_bcd       = 1'b0;
`endif
    end

endmodule

// File: doc/status_reg.md
# status_reg

Processor status (P) register for the 6502 core. Consumes the ALU's registered flag outputs (CO, V, Z, N) plus control-issued flag commands, and holds N, V, D, I, Z, C. Drives the carry-in and BCD-mode inputs back into the ALU. Sits between the microcode/control decoder and the ALU, with a one-entry deferred-update pipeline matching the ALU's one-cycle registered result.

## Interface
- No parameters.
- `clk` in 1: system clock.
- `reset_n` in 1: synchronous, active-low reset.
- `RDY` in 1: global stall. When low, all state except the IRQ synchroniser holds.
- `flag_op` in 4: flag command, sampled when `RDY`=1 (encoding below).
- `alu_CO`, `alu_V`, `alu_Z`, `alu_N` in 1 each: ALU flag outputs, valid the cycle after the ALU op.
- `DB` in 8: data bus, used by PLP and BIT.
- `irq_n` in 1: asynchronous IRQ line, active-low.
- `push_brk` in 1: value presented in bit 4 (B) of `P`.
- `P` out 8: {N, V, 1, push_brk, D, I, Z, C}.
- `C_fwd` out 1: carry-in to the ALU, forwarded.
- `D_bcd` out 1: drives the ALU `BCD` input.
- `irq_pending` out 1: interrupt request to the control unit.

## Operation
- `flag_op` encoding:
  - 0000: none.
  - 0001: NZ deferred.
  - 0010: NZC deferred.
  - 0011: NVZC deferred.
  - 0100: BIT. N←DB[7] and V←DB[6] immediately; Z deferred.
  - 0101: PLP. N,V,D,I,Z,C ← DB[7,6,3,2,1,0] immediately.
  - 0110/0111: CLC/SEC.
  - 1000/1001: CLI/SEI.
  - 1010/1011: CLD/SED.
  - 1100: CLV.
  - 1101: interrupt entry, I←1.
  - 1110, 1111: no-op.
- Deferred ops set pending bits `pn`, `pv`, `pz`, `pc`. At the next `RDY`=1 edge:
  - Each pending flag loads from the corresponding `alu_*` input.
  - All pending bits clear, unless a new deferred op is sampled on that same edge. In that case its pending bits are set (back-to-back ops).
- Same-edge conflict: an immediate write to a flag beats a deferred write to the same flag, because the immediate op is later in program order. Example: ADC then SEC gives C=1.
- `C_fwd` = `pc` ? `alu_CO` : C. This is combinational, so back-to-back ADC/ROL see the fresh carry.
- IRQ:
  - `irq_n` is synchronised through one flop `irq_q` ← ~`irq_n` every clk, not gated by `RDY`.
  - `irq_pending` = `irq_q` & ~I, combinational on the current I.

## Timing
- Reset (`reset_n`=0 at an edge), regardless of `RDY`:
  - N=V=D=Z=C=0, I=1.
  - All pending bits cleared; `irq_q`=0.
  - Outputs after reset: `P`=0x24 | (`push_brk`<<4); `C_fwd`=0; `D_bcd`=0; `irq_pending`=0.
  - Reset mid-deferred-op discards the pending update.
- Deferred op sampled at edge t (ALU computes in cycle t). `alu_*` is valid during cycle t+1. The flags update at edge t+1, and `P` shows them in cycle t+2.
- Immediate ops sampled at edge t: `P` updates in cycle t+1.
- `RDY`=0 at an edge: flags and pending bits hold; `C_fwd` keeps forwarding `alu_CO` while `pc`=1. The ALU is also RDY-gated, so its outputs stay aligned.
- `irq_pending` asserts one clk after `irq_n` falls, given I=0. It deasserts in the cycle after I is set.
- `P` bit 5 is constant 1. `P` bit 4 is combinational from `push_brk` and is not stored.

## Configuration
- `STATUS_DECIMAL_EN` defined: `D_bcd` = D.
- `STATUS_DECIMAL_EN` undefined (2A03-style): `D_bcd` is tied to 0. The D flag is still stored, readable in `P`, and writable by SED/CLD/PLP.

## Test plan
- Reset: hold `reset_n`=0 for 1 edge with `push_brk`=0. Expect `P`=0x24, `C_fwd`=0, `D_bcd`=0, `irq_pending`=0. Repeat with an NVZC op pending at reset; expect no flag change afterward.
- NVZC: `flag_op`=0011 at edge t; during t+1 drive `alu_CO`=1, V=1, Z=0, N=1. Expect `C_fwd`=1 during t+1 and `P`=0xE5 in t+2.
- Back-to-back and override:
  - NZC, then NZC, then SEC on consecutive edges.
  - ALU CO values are 1, then 0.
  - Expect `C_fwd` 1, then 0. SEC and the pending C update collide on the same edge; expect final C=1.
- Stall: `flag_op`=0010 at t, then `RDY`=0 for 3 edges with `alu_CO`=1 held. Expect `P` unchanged and `C_fwd`=1 throughout the stall; C=1 one edge after `RDY` returns.
- PLP: `DB`=0xFF, `flag_op`=0101, `push_brk`=0. Expect `P`=0xEF. Expect `D_bcd`=1 with `STATUS_DECIMAL_EN` defined and 0 without.
- IRQ: CLI, then `irq_n`=0. Expect `irq_pending`=1 after 1 clk. Then `flag_op`=1101; expect I=1 and `irq_pending`=0 in the following cycle.
